// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants for the UART transmit and receive buffers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int c_BYTE_W = 8;

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_WAIT_DONE = 2'd1;
    localparam logic [1:0] c_GAP       = 2'd2;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock circular FIFO with registered count/full/empty
//               and a sticky overflow flag for writes dropped while full.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count,
    output logic             o_overflow
);

    localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_DEPTH_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic             r_empty;
    logic             r_overflow;

    logic             w_wr_acc;
    logic             w_rd_acc;
    logic [CNT_W-1:0] w_count_nxt;

    // Full is judged on the registered flag, so a pop in the same cycle
    // never rescues a write that arrives while full.
    assign w_wr_acc = i_wr_en & ~r_full;
    assign w_rd_acc = i_rd_en & ~r_empty;

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_acc && !w_rd_acc) begin
            w_count_nxt = r_count + c_ONE;
        end else if (!w_wr_acc && w_rd_acc) begin
            w_count_nxt = r_count - c_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (i_wr_en && r_full) begin
                r_overflow <= 1'b1;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_DEPTH_CNT);
            r_empty <= (w_count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    assign o_rd_data  = r_mem[r_rd_ptr];
    assign o_full     = r_full;
    assign o_empty    = r_empty;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module      : uart_tx_fifo
// Description : Host-side byte FIFO that launches bytes into uart_tx one at a
//               time, waiting for Tx_Done plus an idle gap between launches.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int GAP_CLKS = 1
) (
    input  logic                       i_Clock,
    input  logic                       i_Rst_n,
    input  logic                       i_Wr_DV,
    input  logic [7:0]                 i_Wr_Byte,
    output logic                       o_Full,
    output logic                       o_Empty,
    output logic [$clog2(DEPTH+1)-1:0] o_Count,
    output logic                       o_Overflow,
    output logic                       o_Tx_DV,
    output logic [7:0]                 o_Tx_Byte,
    input  logic                       i_Tx_Active,
    input  logic                       i_Tx_Done
);

    localparam logic [7:0] c_GAP_LOAD = 8'(GAP_CLKS - 1);

    logic                w_rst;
    logic [c_BYTE_W-1:0] w_head;
    logic                w_empty;
    logic                w_pop;
    logic                w_gap_load;
    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [7:0]          r_gap_cnt;
    logic                r_tx_dv;
    logic [c_BYTE_W-1:0] r_tx_byte;

    assign w_rst = ~i_Rst_n;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_BYTE_W)
    ) u_fifo (
        .clk        (i_Clock),
        .rst        (w_rst),
        .i_wr_en    (i_Wr_DV),
        .i_wr_data  (i_Wr_Byte),
        .i_rd_en    (w_pop),
        .o_rd_data  (w_head),
        .o_full     (o_Full),
        .o_empty    (w_empty),
        .o_count    (o_Count),
        .o_overflow (o_Overflow)
    );

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:      if (w_pop)              w_state_nxt = c_WAIT_DONE;
            c_WAIT_DONE: if (i_Tx_Done)          w_state_nxt = c_GAP;
            c_GAP:       if (r_gap_cnt == 8'd0)  w_state_nxt = c_IDLE;
            default:                             w_state_nxt = c_IDLE;
        endcase
    end

    // Done pulses outside WAIT_DONE (including after a mid-frame reset) fall through unused.
    always_comb begin
        w_pop      = (r_state == c_IDLE) && !w_empty && !i_Tx_Active;
        w_gap_load = (r_state == c_WAIT_DONE) && i_Tx_Done;
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            r_tx_dv   <= 1'b0;
            r_tx_byte <= '0;
            r_gap_cnt <= '0;
        end else begin
            r_tx_dv <= w_pop;
            if (w_pop) begin
                r_tx_byte <= w_head;
            end
            if (w_gap_load) begin
                r_gap_cnt <= c_GAP_LOAD;
            end else if ((r_state == c_GAP) && (r_gap_cnt != 8'd0)) begin
                r_gap_cnt <= r_gap_cnt - 8'd1;
            end
        end
    end

    assign o_Empty   = w_empty;
    assign o_Tx_DV   = r_tx_dv;
    assign o_Tx_Byte = r_tx_byte;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Bench for uart_tx_fifo with a stub serial transmitter and a
//               queue-and-timestamp reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo;

    localparam int c_DEPTH = 16;
    localparam int c_GAP   = 5;
    localparam int c_FRAME = 20;
    localparam int c_CNT_W = $clog2(c_DEPTH + 1);

    logic clk = 1'b0;
    always #50 clk = ~clk;

    logic               rst_n;
    logic               wr_dv;
    logic [7:0]         wr_byte;
    logic               tx_active;
    logic               tx_done;
    logic               full;
    logic               empty;
    logic [c_CNT_W-1:0] count;
    logic               overflow;
    logic               tx_dv;
    logic [7:0]         tx_byte;

    uart_tx_fifo #(
        .DEPTH    (c_DEPTH),
        .GAP_CLKS (c_GAP)
    ) dut (
        .i_Clock     (clk),
        .i_Rst_n     (rst_n),
        .i_Wr_DV     (wr_dv),
        .i_Wr_Byte   (wr_byte),
        .o_Full      (full),
        .o_Empty     (empty),
        .o_Count     (count),
        .o_Overflow  (overflow),
        .o_Tx_DV     (tx_dv),
        .o_Tx_Byte   (tx_byte),
        .i_Tx_Active (tx_active),
        .i_Tx_Done   (tx_done)
    );

    // Reference model: queue of accepted bytes plus "earliest next launch" time.
    logic [7:0] m_q[$];
    logic       m_ovf;
    logic       m_dv;
    logic [7:0] m_byte;
    logic       m_waiting;
    int         m_next_ok;
    int         cyc;

    int stub_left;
    bit rand_busy;
    int n_total;
    int n_bad;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_edge();
        bit was_full;
        bit launch;
        if (!rst_n) begin
            m_q.delete();
            m_ovf     = 1'b0;
            m_dv      = 1'b0;
            m_byte    = 8'h00;
            m_waiting = 1'b0;
            m_next_ok = 0;
        end else begin
            was_full = (m_q.size() == c_DEPTH);
            launch   = !m_waiting && (cyc >= m_next_ok) && (m_q.size() > 0) && !tx_active;
            if (m_waiting && tx_done) begin
                m_waiting = 1'b0;
                m_next_ok = cyc + c_GAP + 1;
            end
            m_dv = launch;
            if (launch) begin
                m_byte    = m_q.pop_front();
                m_waiting = 1'b1;
            end
            if (wr_dv) begin
                if (was_full) m_ovf = 1'b1;
                else          m_q.push_back(wr_byte);
            end
        end
        cyc++;
    endtask

    task automatic check_outputs();
        check_val("count",    32'(count),    32'(m_q.size()));
        check_val("full",     32'(full),     32'(m_q.size() == c_DEPTH));
        check_val("empty",    32'(empty),    32'(m_q.size() == 0));
        check_val("overflow", 32'(overflow), 32'(m_ovf));
        check_val("tx_dv",    32'(tx_dv),    32'(m_dv));
        check_val("tx_byte",  32'(tx_byte),  32'(m_byte));
    endtask

    // Drive one cycle of inputs at the falling edge, model the rising edge, check.
    task automatic step(input logic wr, input logic [7:0] b, input logic rn);
        wr_dv   = wr;
        wr_byte = b;
        rst_n   = rn;
        tx_done = 1'b0;
        if (tx_dv) begin
            stub_left = c_FRAME;
            tx_active = 1'b1;
        end else if (stub_left > 0) begin
            stub_left--;
            if (stub_left == 0) begin
                tx_active = 1'b0;
                tx_done   = 1'b1;
            end
        end else begin
            tx_active = rand_busy && ($urandom_range(0, 7) == 0);
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; wr_dv = 1'b0; wr_byte = 8'h00;
        tx_active = 1'b0; tx_done = 1'b0;
        m_ovf = 1'b0; m_dv = 1'b0; m_byte = 8'h00; m_waiting = 1'b0;
        m_next_ok = 0; cyc = 0; stub_left = 0; rand_busy = 0;
        n_total = 0; n_bad = 0;

        @(negedge clk);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);

        // single byte
        step(1'b1, 8'h3F, 1'b1);
        idle(60);

        // burst 01..05
        for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 1'b1);
        idle(5 * (c_FRAME + c_GAP + 4));

        // overflow: one byte launches first, then 17 more find the FIFO filling
        step(1'b1, 8'h0F, 1'b1);
        idle(3);
        for (int i = 8'h10; i <= 8'h20; i++) step(1'b1, 8'(i), 1'b1);
        idle(18 * (c_FRAME + c_GAP + 4));

        // reset clears the sticky overflow
        step(1'b0, 8'h00, 1'b0);

        // wrap-around rounds
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 12; i++) step(1'b1, 8'(8'h40 + r * 12 + i), 1'b1);
            idle(12 * (c_FRAME + c_GAP + 4));
        end

        // reset mid-frame with bytes queued, then a fresh byte
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hB0 + i), 1'b1);
        idle(4);
        step(1'b0, 8'h00, 1'b0);
        idle(c_FRAME + 4);
        step(1'b1, 8'hA5, 1'b1);
        idle(c_FRAME + c_GAP + 10);

        // randomized traffic with occasional foreign line activity and resets
        rand_busy = 1;
        for (int i = 0; i < 3000; i++) begin
            step(1'(($urandom_range(0, 2) == 0)), 8'($urandom), 1'(($urandom_range(0, 499) != 0)));
        end
        rand_busy = 0;
        idle(c_DEPTH * (c_FRAME + c_GAP + 4));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
